// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ctrl decisions, instruction memory port and the
// decoded instruction stream handed to ctrl.
interface inst_fetch_if;
    logic [1:0]  pc_sel;
    logic [1:0]  inst_sel;
    logic [31:0] target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        inst_valid;
    logic        misalign_err;
    logic [31:0] cnt_fetch;
    logic [31:0] cnt_bubble;

    modport master (
        output pc_sel, inst_sel, target, imem_rdata,
        input  imem_addr, pc, pc_plus4, inst, opcode, func3, func7,
               inst_valid, misalign_err, cnt_fetch, cnt_bubble
    );

    modport slave (
        input  pc_sel, inst_sel, target, imem_rdata,
        output imem_addr, pc, pc_plus4, inst, opcode, func3, func7,
               inst_valid, misalign_err, cnt_fetch, cnt_bubble
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem addressing, redirect/hold/bubble handling.
// Optional performance counters are built when INST_FETCH_PERF_CNT_EN is defined.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.slave  bus
);
    typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt, ir_q, inst;
    logic        err_q, valid;

    always_comb begin
        pc_nxt    = pc_q + 32'd4;
        state_nxt = RUN;
        if (rst) begin
            pc_nxt    = RESET_PC;
            state_nxt = RUN;
        end else if (bus.pc_sel == 2'b01) begin
            pc_nxt    = {bus.target[31:2], 2'b00};
            state_nxt = RUN;
        end else if (bus.pc_sel == 2'b10) begin
            pc_nxt    = pc_q;
            state_nxt = HOLD;
        end else begin
            // The word displaced by the bubble is re-fetched so none is lost.
            if (state == BUBBLE) pc_nxt = pc_q;
            state_nxt = (bus.inst_sel == 2'b01) ? BUBBLE : RUN;
        end
    end

    always_comb begin
        inst = bus.imem_rdata;
        if (!rst) begin
            case (state)
                HOLD:    inst = ir_q;
                BUBBLE:  inst = NOP_INST;
                default: inst = bus.imem_rdata;
            endcase
        end
    end

    assign valid = !rst && (state != BUBBLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ir_q  <= NOP_INST;
            state <= RUN;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            ir_q  <= inst;
            state <= state_nxt;
            if (bus.pc_sel == 2'b01 && bus.target[1:0] != 2'b00) err_q <= 1'b1;
        end
    end

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] cnt_fetch_q, cnt_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_fetch_q  <= 32'd0;
            cnt_bubble_q <= 32'd0;
        end else begin
            if (valid && state == RUN) cnt_fetch_q <= cnt_fetch_q + 32'd1;
            if (state == BUBBLE || state == HOLD) cnt_bubble_q <= cnt_bubble_q + 32'd1;
        end
    end

    assign bus.cnt_fetch  = cnt_fetch_q;
    assign bus.cnt_bubble = cnt_bubble_q;
`else
    assign bus.cnt_fetch  = 32'h0;
    assign bus.cnt_bubble = 32'h0;
`endif

    assign bus.imem_addr    = pc_nxt;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'd4;
    assign bus.inst         = inst;
    assign bus.opcode       = inst[6:2];
    assign bus.func3        = inst[14:12];
    assign bus.func7        = inst[31:25];
    assign bus.inst_valid   = valid;
    assign bus.misalign_err = err_q;
endmodule
